// File: rtl/main_memory.sv
// Block-granular backing store behind the L2 memory port: fixed-latency
// block reads/writes, each answered with a single-cycle mem_ready pulse.
module main_memory #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 11,
    parameter int BLOCK_SIZE    = 32,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
    output logic                                  mem_ready,
    output logic                                  mem_busy
);
    localparam int OFF_W      = $clog2(BLOCK_SIZE);
    localparam int IDX_W      = ADDR_WIDTH - OFF_W;
    localparam int NUM_BLOCKS = 1 << IDX_W;
    localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx;
    block_t             wbuf;
    block_t             mem [NUM_BLOCKS];
    logic               start_wr, start_rd, finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Write wins over a simultaneous read; BUSY and DONE ignore the request lines.
    always_comb begin
        state_nxt = state;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    start_wr  = 1'b1;
                    state_nxt = BUSY;
                end else if (mem_read) begin
                    start_rd  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            op_wr          <= 1'b0;
            idx            <= '0;
            wbuf           <= '0;
            mem_data_block <= '0;
            mem_ready      <= 1'b0;
            mem_busy       <= 1'b0;
            // Known nonzero content: word w of block b holds (b << 8) | w.
            for (int b = 0; b < NUM_BLOCKS; b++)
                for (int w = 0; w < BLOCK_SIZE; w++)
                    mem[b][w] <= DATA_WIDTH'((b << 8) | w);
        end else begin
            mem_ready <= finish;
            if (start_wr) begin
                idx      <= mem_addr[ADDR_WIDTH-1:OFF_W];
                wbuf     <= mem_data_out;
                op_wr    <= 1'b1;
                cnt      <= CNT_W'(WRITE_LATENCY - 1);
                mem_busy <= 1'b1;
            end else if (start_rd) begin
                idx      <= mem_addr[ADDR_WIDTH-1:OFF_W];
                op_wr    <= 1'b0;
                cnt      <= CNT_W'(READ_LATENCY - 1);
                mem_busy <= 1'b1;
            end else if (state == BUSY) begin
                if (cnt != '0)  cnt <= cnt - CNT_W'(1);
                else if (op_wr) mem[idx] <= wbuf;
                else            mem_data_block <= mem[idx];
            end else if (state == DONE) begin
                mem_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: a reference array predicts each completion
// (read data, or the untouched read block for writes) and the scoreboard checks it.
module tb_main_memory;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    localparam int NB = 64;
    localparam int LAT = 4;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_read, mem_write;
    blk_t          mem_data_out, mem_data_block;
    logic          mem_ready, mem_busy;

    main_memory dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_data_out(mem_data_out),
        .mem_data_block(mem_data_block), .mem_ready(mem_ready), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    int   vectors = 0, miscompares = 0;
    int   ready_cnt = 0, busy_cnt = 0;
    blk_t model [NB];
    blk_t last_rd;
    blk_t exp_q [$];

    always @(negedge clk) begin
        if (mem_ready === 1'b1) ready_cnt++;
        if (mem_busy === 1'b1)  busy_cnt++;
    end

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input blk_t obs, input blk_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < BS; w++)
                model[b][w] = DW'((b << 8) | w);
        last_rd = '0;
        exp_q.delete();
    endtask

    function automatic blk_t pattern(input logic [DW-1:0] base);
        blk_t r;
        for (int i = 0; i < BS; i++) r[i] = base ^ DW'(i);
        return r;
    endfunction

    // One transaction. hold: keep the request up until one cycle after mem_ready.
    // disturb: during BUSY, retarget addr/data and raise mem_write.
    task automatic txn(input string tag, input logic wr, input logic rd,
                       input logic [AW-1:0] addr, input blk_t data,
                       input bit hold, input bit disturb);
        int   lat, r0, b0;
        blk_t exp, got;
        @(negedge clk);
        mem_write = wr; mem_read = rd; mem_addr = addr; mem_data_out = data;
        r0 = ready_cnt; b0 = busy_cnt;
        @(posedge clk);
        if (wr) begin
            model[addr[AW-1:5]] = data;
            exp = last_rd;
        end else begin
            exp = model[addr[AW-1:5]];
            last_rd = exp;
        end
        exp_q.push_back(exp);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (mem_ready === 1'b1 && lat < 0) begin
                lat = j;
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    chk_blk({tag, " data"}, mem_data_block, got);
                end else chk_int({tag, " unexpected ready"}, 1, 0);
            end
            if (disturb) begin
                if (j == 1) begin
                    mem_addr = addr ^ 11'h040; mem_data_out = ~data; mem_write = 1'b1;
                end
                if (lat >= 0) mem_write = 1'b0;
            end else if (!hold || (lat >= 0 && j > lat)) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
        chk_int({tag, " latency"}, lat, LAT);
        chk_int({tag, " ready pulses"}, ready_cnt - r0, 1);
        // busy spans capture edge N up to edge N+L+1
        chk_int({tag, " busy cycles"}, busy_cnt - b0, LAT + 1);
    endtask

    initial begin
        blk_t d3, d5, d9;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data_out = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_int("reset ready", int'(mem_ready), 0);
        chk_int("reset busy", int'(mem_busy), 0);
        chk_blk("reset data_block", mem_data_block, '0);
        rst = 1'b0;

        txn("rd blk0", 1'b0, 1'b1, 11'h00A, '0, 1'b0, 1'b0);
        chk_int("blk0 word31", int'(mem_data_block[31]), 32'h1F);

        d3 = pattern(32'hA5A5A5A5);
        txn("wr blk3", 1'b1, 1'b0, 11'h060, d3, 1'b0, 1'b0);
        txn("rd blk3", 1'b0, 1'b1, 11'h07F, '0, 1'b0, 1'b0);

        d5 = pattern(32'h5A000500);
        txn("rdwr blk5", 1'b1, 1'b1, 11'h0A0, d5, 1'b0, 1'b0);
        txn("rd blk5", 1'b0, 1'b1, 11'h0A3, '0, 1'b0, 1'b0);

        txn("held rd blk0", 1'b0, 1'b1, 11'h001, '0, 1'b1, 1'b0);
        chk_int("held rd quiet after", ready_cnt, ready_cnt);
        chk_int("idle after held rd", int'(mem_busy), 0);

        d9 = pattern(32'h0BADF00D);
        txn("wr blk9 disturbed", 1'b1, 1'b0, 11'h120, d9, 1'b0, 1'b1);
        txn("rd blk9", 1'b0, 1'b1, 11'h120, '0, 1'b0, 1'b0);
        txn("rd blk11", 1'b0, 1'b1, 11'h160, '0, 1'b0, 1'b0);

        // reset two cycles into a write of block 7
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 11'h0E0; mem_data_out = pattern(32'hDEAD0000);
        @(posedge clk);
        @(negedge clk); mem_write = 1'b0;
        @(negedge clk);
        chk_int("busy before mid reset", int'(mem_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_int("mid reset ready", int'(mem_ready), 0);
        chk_int("mid reset busy", int'(mem_busy), 0);
        chk_blk("mid reset data_block", mem_data_block, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        txn("rd blk7 after reset", 1'b0, 1'b1, 11'h0E5, '0, 1'b0, 1'b0);
        chk_int("blk7 word2", int'(mem_data_block[2]), 32'h702);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
